// File: rtl/mult_div_sequencer.sv
// Iterative HI/LO multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Optional MDU_EARLY_TERM_EN: finish MUL early once the remaining multiplier bits are zero.
module mult_div_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e             state_q;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q;
  logic               sign_q;     // product sign, or quotient sign for divide
  logic               rsign_q;    // remainder sign (follows the dividend)
  logic [WIDTH-1:0]   opa_q;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   shreg_q;    // multiplier shifting out, or dividend/quotient shifting through
  logic [WIDTH-1:0]   rem_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               busy_q, done_q, dbz_q;
  logic [WIDTH-1:0]   high_q, low_q;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_d;
  logic [WIDTH:0]     div_r, div_diff;
  logic               quo_bit;
  logic [WIDTH-1:0]   rem_d, quo_d;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    signed_op  = ~Op[0];
    abs_a      = (signed_op && A[WIDTH-1]) ? -A : A;
    abs_b      = (signed_op && B[WIDTH-1]) ? -B : B;

    mul_addend = shreg_q[0] ? opa_q : '0;
    mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
    acc_d      = {mul_sum, acc_q[WIDTH-1:1]};
    mplier_d   = shreg_q >> 1;

    // The partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
    div_r      = {rem_q, shreg_q[WIDTH-1]};
    div_diff   = div_r - {1'b0, opa_q};
    quo_bit    = ~div_diff[WIDTH];
    rem_d      = quo_bit ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
    quo_d      = {shreg_q[WIDTH-2:0], quo_bit};

    prod_fix   = sign_q  ? -acc_q   : acc_q;
    quo_fix    = sign_q  ? -shreg_q : shreg_q;
    rem_fix    = rsign_q ? -rem_q   : rem_q;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      opa_q    <= '0;
      shreg_q  <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      high_q   <= '0;
      low_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (Start) begin
            case (Op)
              3'b000, 3'b001: begin
                state_q  <= StMul;
                busy_q   <= 1'b1;
                is_div_q <= 1'b0;
                opa_q    <= abs_a;
                shreg_q  <= abs_b;
                sign_q   <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                acc_q    <= '0;
                cnt_q    <= CntLast;
              end
              3'b010, 3'b011: begin
                if (B == '0) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  dbz_q   <= 1'b1;
                  high_q  <= A;
                  low_q   <= '1;
                end else begin
                  state_q  <= StDiv;
                  busy_q   <= 1'b1;
                  is_div_q <= 1'b1;
                  opa_q    <= abs_b;
                  shreg_q  <= abs_a;
                  rem_q    <= '0;
                  sign_q   <= signed_op & (A[WIDTH-1] ^ B[WIDTH-1]);
                  rsign_q  <= signed_op & A[WIDTH-1];
                  cnt_q    <= CntLast;
                end
              end
              3'b100:  high_q <= A;
              3'b101:  low_q  <= A;
              default: ;
            endcase
          end
        end
        StMul: begin
`ifdef MDU_EARLY_TERM_EN
          if (cnt_q != CntLast && shreg_q == '0) begin
            // Remaining steps only shift; cnt_q+1 cannot wrap since cnt_q < WIDTH-1 here.
            acc_q   <= acc_q >> (cnt_q + CntW'(1));
            cnt_q   <= '0;
            state_q <= StFix;
          end else begin
            acc_q   <= acc_d;
            shreg_q <= mplier_d;
            cnt_q   <= cnt_q - CntW'(1);
            if (cnt_q == '0) state_q <= StFix;
          end
`else
          acc_q   <= acc_d;
          shreg_q <= mplier_d;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == '0) state_q <= StFix;
`endif
        end
        StDiv: begin
          rem_q   <= rem_d;
          shreg_q <= quo_d;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == '0) state_q <= StFix;
        end
        StFix: begin
          if (is_div_q) begin
            high_q <= rem_fix;
            low_q  <= quo_fix;
          end else begin
            high_q <= prod_fix[2*WIDTH-1:WIDTH];
            low_q  <= prod_fix[WIDTH-1:0];
          end
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivByZero = dbz_q;
  assign High      = high_q;
  assign Low       = low_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomized bench for mult_div_sequencer against a cycle-count/arithmetic reference model.
module tb_mult_div_sequencer;

  localparam int unsigned W = 32;

  logic          CLK = 1'b0;
  logic          Reset, Start;
  logic [2:0]    Op;
  logic [W-1:0]  A, B;
  logic          Busy, Done, DivByZero;
  logic [W-1:0]  High, Low;

  int checks = 0;
  int fails  = 0;

  mult_div_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .High(High), .Low(Low)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_fn(input logic [2:0] op, input logic [W-1:0] a, b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = sa * sb; return p; end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Reference model: busy for W+1 cycles after an accepted Start, result with Done.
  int          m_busy_left;
  logic [63:0] m_pend;
  logic [W-1:0] m_high, m_low;
  logic        m_done, m_dbz;

  always @(posedge CLK) begin
    if (Reset) begin
      m_busy_left = 0; m_high = '0; m_low = '0; m_done = 0; m_dbz = 0;
    end else begin
      m_done = 0;
      m_dbz  = 0;
      if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) begin
          {m_high, m_low} = m_pend;
          m_done = 1;
        end
      end else if (Start) begin
        case (Op)
          3'd0, 3'd1: begin m_pend = ref_fn(Op, A, B); m_busy_left = W + 1; end
          3'd2, 3'd3: begin
            if (B == '0) begin
              m_high = A; m_low = '1; m_done = 1; m_dbz = 1;
            end else begin
              m_pend = ref_fn(Op, A, B); m_busy_left = W + 1;
            end
          end
          3'd4: m_high = A;
          3'd5: m_low  = A;
          default: ;
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    chk("busy", Busy, m_busy_left > 0);
    chk("done", Done, m_done);
    chk("dbz", DivByZero, m_dbz);
    chk("high", High, m_high);
    chk("low", Low, m_low);
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, b);
    @(negedge CLK);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 1;
    while (Done !== 1'b1 && n < max) begin
      @(negedge CLK);
      n++;
    end
    if (Done !== 1'b1) begin
      fails++;
      $display("FAIL wait_done timeout got=%0d cycles expected<%0d", n, max);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a, b,
                        input int exp_cyc, input logic [W-1:0] exp_hi, exp_lo,
                        input logic exp_dbz);
    int n;
    issue(op, a, b);
    wait_done(100, n);
    chk({nm, "_cycle"}, n, exp_cyc);
    chk({nm, "_hi"}, High, exp_hi);
    chk({nm, "_lo"}, Low, exp_lo);
    chk({nm, "_dbz"}, DivByZero, exp_dbz);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic saw;
    Reset = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_high", High, 0);
    chk("rst_low", Low, 0);
    Reset = 1'b0;

    chk("model_multu", ref_fn(3'd1, 32'h0000054A, 32'h000015ED), 64'h00000000_0073F782);
    chk("model_mult", ref_fn(3'd0, 32'hFFFFFFFF, 32'd2), 64'hFFFFFFFF_FFFFFFFE);
    chk("model_div", ref_fn(3'd2, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
    chk("model_divovf", ref_fn(3'd2, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);

    run_op("multu_a", 3'd1, 32'h0000054A, 32'h000015ED, 34, 32'h0, 32'h0073F782, 1'b0);
    run_op("mult_neg", 3'd0, 32'hFFFFFFFF, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    run_op("multu_b", 3'd1, 32'hFFFFFFFF, 32'd2, 34, 32'h1, 32'hFFFFFFFE, 1'b0);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu", 3'd3, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);
    run_op("divu_z", 3'd3, 32'h12345678, 32'd0, 1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0);

    // Back-to-back MTHI/MTLO.
    @(negedge CLK);
    Start = 1'b1; Op = 3'd4; A = 32'hDEADBEEF;
    @(negedge CLK);
    chk("mthi_busy", {Busy, Done}, 0);
    Op = 3'd5; A = 32'h01234567;
    @(negedge CLK);
    Start = 1'b0;
    chk("mtlo_busy", {Busy, Done}, 0);
    chk("mthi_high", High, 32'hDEADBEEF);
    chk("mtlo_low", Low, 32'h01234567);

    // Start while busy is ignored; Reset aborts with no Done.
    issue(3'd0, 32'd3, 32'd5);
    repeat (3) @(negedge CLK);
    Start = 1'b1; Op = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge CLK);
    Start = 1'b0;
    repeat (4) @(negedge CLK);
    Reset = 1'b1;
    @(negedge CLK);
    Reset = 1'b0;
    chk("abort_busy", Busy, 0);
    chk("abort_high", High, 0);
    chk("abort_low", Low, 0);
    saw = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      saw = saw | Done;
    end
    chk("abort_nodone", saw, 0);

    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      Start = ($urandom_range(0, 2) == 0);
      Op    = 3'($urandom_range(0, 7));
      A     = pick();
      B     = pick();
      Reset = ($urandom_range(0, 799) == 0);
    end
    @(negedge CLK);
    Start = 1'b0; Reset = 1'b0;
    repeat (40) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
